ui_fill_sequencer: RTL and testbench
====================================

UI_FILL_SEQUENCER -- requirements
Module: ui_fill_sequencer

Interface
REQ-001 Parameter X_BITS, default 6, tile-column address width (64 columns).
REQ-002 Parameter Y_BITS, default 5, tile-row address width (32 rows).
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 cpu_we  in  1  direct tile write request, one write per cycle.
REQ-006 cpu_addr  in  X_BITS+Y_BITS  direct write address {col,row}.
REQ-007 cpu_din  in  2  direct write tile value.
REQ-008 cmd_valid  in  1  rectangle-fill command present.
REQ-009 cmd_ready  out  1  sequencer can accept a command.
REQ-010 cmd_x  in  X_BITS  and cmd_y  in  Y_BITS: top-left tile of the rectangle.
REQ-011 cmd_w  in  X_BITS+1  and cmd_h  in  Y_BITS+1: rectangle size in tiles, 0 allowed.
REQ-012 cmd_val  in  2  fill tile value.
REQ-013 we  out  1, addr  out  X_BITS+Y_BITS, din  out  2: registered write port to the tile map.
REQ-014 busy  out  1  fill in progress; done  out  1  one-cycle completion pulse.

Function
REQ-015 States: IDLE, FILL, DONE; cmd_ready SHALL be 1 only in IDLE.
REQ-016 IDLE: cmd_valid&cmd_ready latches x/y/w/h/val and enters FILL; w=0 or h=0 enters DONE directly with no writes.
REQ-017 FILL: one tile written per cycle, row-major, column inner loop from cmd_x, row outer loop from cmd_y.
REQ-018 The first fill write SHALL appear on we/addr/din the cycle after command acceptance.
REQ-019 addr SHALL be {col[X_BITS-1:0], row[Y_BITS-1:0]}, matching the map read index {CounterX[9:4],CounterY[8:4]}.
REQ-020 Clipping: tiles with col>2^X_BITS-1 or row>2^Y_BITS-1 SHALL be skipped, with no write issued and no wrap-around. A row that clips SHALL advance to the next row in the same cycle as its last in-range tile.
REQ-021 Arbitration: cpu_we SHALL have priority; when cpu_we=1 the outputs carry cpu_addr/cpu_din and the fill walker holds its position.
REQ-022 cpu_we SHALL be honoured in every state, with one-cycle registered latency.
REQ-023 After the last in-range tile is written, the FSM enters DONE; DONE asserts done for one cycle, then returns to IDLE.
REQ-024 busy SHALL be 1 in FILL and DONE.
REQ-025 A fill of N in-range tiles with no CPU contention SHALL take exactly N write cycles. done SHALL assert the cycle after the last write.
REQ-026 cmd_valid while not ready SHALL be ignored; the command is not queued.

Reset
REQ-027 rst_n=0 SHALL immediately force IDLE, we=0, addr=0, din=0, busy=0, done=0, and cmd_ready=1 after release.
REQ-028 Reset during FILL SHALL abort the fill; no further writes are issued and no done pulse is produced.

Configuration
REQ-029 Macro UI_FILL_CLEAR_EN, when defined, SHALL add input clear_req (1 bit).
REQ-030 With UI_FILL_CLEAR_EN: clear_req in IDLE SHALL start a fill equivalent to (0,0,2^X_BITS,2^Y_BITS,0) and SHALL win over a simultaneous cmd_valid. cmd_ready SHALL be 0 in that cycle.
REQ-031 Without UI_FILL_CLEAR_EN: the clear_req port and its logic SHALL be absent, and behaviour SHALL be otherwise identical.

Structure
REQ-032 Package ui_pkg SHALL hold X_BITS/Y_BITS defaults, the tile-value typedef (2 bits), the tile-address typedef and the FSM state enum.
REQ-033 Sub-module ui_rect_walker SHALL implement the col/row counters, clipping and last-tile detection. The top level SHALL hold the FSM, arbitration and output registers.

Verification
REQ-034 Fill (2,3,w=3,h=2,val=1) -> writes to addrs {2,3},{3,3},{4,3},{2,4},{3,4},{4,4} on 6 consecutive cycles, then done 1 cycle later.
REQ-035 Fill (62,31,w=4,h=3,val=2) -> only {62,31},{63,31} written, then done; no wrapped addresses.
REQ-036 Fill w=0,h=5 -> no we pulses; done asserted within 2 cycles of acceptance.
REQ-037 cpu_we=1 on cycles 2–3 of a 4-tile fill -> CPU writes appear on those cycles, fill completes after 6 write cycles, and no tile is skipped or duplicated.
REQ-038 rst_n low mid-fill -> we=0 immediately, no done pulse, cmd_ready=1 after release.
REQ-039 With UI_FILL_CLEAR_EN, clear_req and cmd_valid together -> 2048 writes of value 0 in address order and the command is ignored; done after the last write.

Source files
------------

// File: rtl/ui_fill_sequencer_pkg.sv
// Shared types for the tile-map rectangle fill sequencer.
// Holds map geometry defaults, tile types and the FSM state encoding.
package ui_pkg;

    localparam int X_BITS_DEF = 6;
    localparam int Y_BITS_DEF = 5;

    typedef logic [1:0] tile_t;
    typedef logic [X_BITS_DEF+Y_BITS_DEF-1:0] taddr_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/ui_fill_sequencer_if.sv
// Command, CPU write and tile-map write port bundle of the fill sequencer.
// The master side drives requests; the slave side is the sequencer.
interface ui_fill_if
    import ui_pkg::*;
#(
    parameter int X_BITS = X_BITS_DEF,
    parameter int Y_BITS = Y_BITS_DEF
) ();

    logic                     cpu_we;
    logic [X_BITS+Y_BITS-1:0] cpu_addr;
    tile_t                    cpu_din;

    logic                     cmd_valid;
    logic                     cmd_ready;
    logic [X_BITS-1:0]        cmd_x;
    logic [Y_BITS-1:0]        cmd_y;
    logic [X_BITS:0]          cmd_w;
    logic [Y_BITS:0]          cmd_h;
    tile_t                    cmd_val;

    logic                     we;
    logic [X_BITS+Y_BITS-1:0] addr;
    tile_t                    din;
    logic                     busy;
    logic                     done;

    modport master (
        output cpu_we, cpu_addr, cpu_din,
        output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_val,
        input  cmd_ready, we, addr, din, busy, done
    );

    modport slave (
        input  cpu_we, cpu_addr, cpu_din,
        input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_val,
        output cmd_ready, we, addr, din, busy, done
    );

endinterface

// File: rtl/ui_fill_sequencer_rect_walker.sv
// Row-major rectangle walker with clipping to the map edge.
// Loading and stepping in the same cycle emits the first tile immediately.
module ui_rect_walker
    import ui_pkg::*;
#(
    parameter int X_BITS = X_BITS_DEF,
    parameter int Y_BITS = Y_BITS_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_load,
    input  logic                     i_step,
    input  logic [X_BITS-1:0]        i_x,
    input  logic [Y_BITS-1:0]        i_y,
    input  logic [X_BITS:0]          i_w,
    input  logic [Y_BITS:0]          i_h,
    output logic [X_BITS+Y_BITS-1:0] o_addr,
    output logic                     o_last
);

    localparam int CW = X_BITS + 2;
    localparam int RW = Y_BITS + 2;
    localparam logic [CW-1:0] C_MAX = {2'b01, {X_BITS{1'b0}}};
    localparam logic [RW-1:0] R_MAX = {2'b01, {Y_BITS{1'b0}}};
    localparam logic [CW-1:0] C_ONE = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [RW-1:0] R_ONE = {{(RW-1){1'b0}}, 1'b1};

    logic [CW-1:0] r_x0, r_col, r_clim;
    logic [RW-1:0] r_row, r_rlim;

    logic [CW-1:0] w_csum, w_x0, w_col, w_clim;
    logic [RW-1:0] w_rsum, w_row, w_rlim;
    logic          w_col_end;

    // Limits are clamped at load so clipped tiles are never visited.
    always_comb begin
        w_csum = {2'b00, i_x} + {1'b0, i_w};
        w_rsum = {2'b00, i_y} + {1'b0, i_h};
        if (i_load) begin
            w_x0   = {2'b00, i_x};
            w_col  = {2'b00, i_x};
            w_row  = {2'b00, i_y};
            w_clim = (w_csum > C_MAX) ? C_MAX : w_csum;
            w_rlim = (w_rsum > R_MAX) ? R_MAX : w_rsum;
        end else begin
            w_x0   = r_x0;
            w_col  = r_col;
            w_row  = r_row;
            w_clim = r_clim;
            w_rlim = r_rlim;
        end
        w_col_end = (w_col == w_clim - C_ONE);
        o_last    = w_col_end && (w_row == w_rlim - R_ONE);
        o_addr    = {w_col[X_BITS-1:0], w_row[Y_BITS-1:0]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x0   <= '0;
            r_col  <= '0;
            r_row  <= '0;
            r_clim <= '0;
            r_rlim <= '0;
        end else if (i_load || i_step) begin
            r_x0   <= w_x0;
            r_clim <= w_clim;
            r_rlim <= w_rlim;
            if (i_step && w_col_end) begin
                r_col <= w_x0;
                r_row <= w_row + R_ONE;
            end else if (i_step) begin
                r_col <= w_col + C_ONE;
                r_row <= w_row;
            end else begin
                r_col <= w_col;
                r_row <= w_row;
            end
        end
    end

endmodule

// File: rtl/ui_fill_sequencer.sv
// Tile-map rectangle fill sequencer: FSM, CPU-priority arbitration, write port.
// Optional UI_FILL_CLEAR_EN adds clear_req, a whole-map fill with value 0.
module ui_fill_sequencer
    import ui_pkg::*;
#(
    parameter int X_BITS = X_BITS_DEF,
    parameter int Y_BITS = Y_BITS_DEF
) (
    input  logic clk,
    input  logic rst_n,
`ifdef UI_FILL_CLEAR_EN
    input  logic clear_req,
`endif
    ui_fill_if.slave bus
);

    state_t r_state, w_next;

    logic                     r_fin;
    tile_t                    r_val;
    logic                     r_we;
    logic [X_BITS+Y_BITS-1:0] r_addr;
    tile_t                    r_din;

    logic                     w_clear;
    logic                     w_accept;
    logic                     w_start;
    logic                     w_empty;
    logic                     w_load;
    logic                     w_issue;
    logic                     w_last;
    logic [X_BITS-1:0]        w_ld_x;
    logic [Y_BITS-1:0]        w_ld_y;
    logic [X_BITS:0]          w_ld_w;
    logic [Y_BITS:0]          w_ld_h;
    tile_t                    w_ld_val;
    tile_t                    w_val;
    logic [X_BITS+Y_BITS-1:0] w_fill_addr;

`ifdef UI_FILL_CLEAR_EN
    assign w_clear = clear_req && (r_state == S_IDLE);
`else
    assign w_clear = 1'b0;
`endif

    assign bus.cmd_ready = (r_state == S_IDLE) && !w_clear;
    assign w_accept      = bus.cmd_valid && bus.cmd_ready;
    assign w_start       = w_accept || w_clear;

    always_comb begin
        w_ld_x   = bus.cmd_x;
        w_ld_y   = bus.cmd_y;
        w_ld_w   = bus.cmd_w;
        w_ld_h   = bus.cmd_h;
        w_ld_val = bus.cmd_val;
        if (w_clear) begin
            w_ld_x   = '0;
            w_ld_y   = '0;
            w_ld_w   = {1'b1, {X_BITS{1'b0}}};
            w_ld_h   = {1'b1, {Y_BITS{1'b0}}};
            w_ld_val = '0;
        end
        w_empty = (w_ld_w == '0) || (w_ld_h == '0);
        w_val   = (r_state == S_IDLE) ? w_ld_val : r_val;
    end

    // The first tile is issued in the accept cycle; r_fin then spends
    // one FILL cycle so done lands the cycle after the last write.
    always_comb begin
        w_next  = r_state;
        w_load  = 1'b0;
        w_issue = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_load = 1'b1;
                    if (w_empty) begin
                        w_next = S_DONE;
                    end else begin
                        w_issue = !bus.cpu_we;
                        w_next  = S_FILL;
                    end
                end
            end
            S_FILL: begin
                if (r_fin) w_next = S_DONE;
                else       w_issue = !bus.cpu_we;
            end
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    ui_rect_walker #(
        .X_BITS (X_BITS),
        .Y_BITS (Y_BITS)
    ) u_walker (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_load),
        .i_step (w_issue),
        .i_x    (w_ld_x),
        .i_y    (w_ld_y),
        .i_w    (w_ld_w),
        .i_h    (w_ld_h),
        .o_addr (w_fill_addr),
        .o_last (w_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_fin   <= 1'b0;
            r_val   <= '0;
        end else begin
            r_state <= w_next;
            r_fin   <= w_issue && w_last;
            if (w_load) r_val <= w_ld_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we   <= 1'b0;
            r_addr <= '0;
            r_din  <= '0;
        end else if (bus.cpu_we) begin
            r_we   <= 1'b1;
            r_addr <= bus.cpu_addr;
            r_din  <= bus.cpu_din;
        end else if (w_issue) begin
            r_we   <= 1'b1;
            r_addr <= w_fill_addr;
            r_din  <= w_val;
        end else begin
            r_we   <= 1'b0;
        end
    end

    assign bus.we   = r_we;
    assign bus.addr = r_addr;
    assign bus.din  = r_din;
    assign bus.busy = (r_state != S_IDLE);
    assign bus.done = (r_state == S_DONE);

endmodule

// File: tb/tb_ui_fill_sequencer.sv
// Scoreboard bench for ui_fill_sequencer: expected writes queued at stimulus,
// observed writes and done pulses queued by a monitor and compared per test.
module tb_ui_fill_sequencer;

    typedef struct {
        logic [10:0] addr;
        logic [1:0]  din;
    } exp_t;

    typedef struct {
        int          cyc;
        logic [10:0] addr;
        logic [1:0]  din;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clear_req = 1'b0;
    int   cyc_n = 0;
    int   errors = 0;
    int   checks = 0;

    exp_t exp_q[$];
    obs_t obs_q[$];
    int   done_q[$];

    ui_fill_if #(.X_BITS(6), .Y_BITS(5)) bus ();

    ui_fill_sequencer #(.X_BITS(6), .Y_BITS(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef UI_FILL_CLEAR_EN
        .clear_req (clear_req),
`endif
        .bus       (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.we) obs_q.push_back('{cyc_n, bus.addr, bus.din});
            if (bus.done) done_q.push_back(cyc_n);
        end
    end

    function automatic logic [10:0] ta(int c, int r);
        logic [5:0] cc;
        logic [4:0] rr;
        cc = c[5:0];
        rr = r[4:0];
        return {cc, rr};
    endfunction

    task automatic push_one(logic [10:0] a, logic [1:0] d);
        exp_q.push_back('{a, d});
    endtask

    task automatic push_fill(int x, int y, int w, int h, int v);
        for (int r = y; r < y + h; r++)
            for (int c = x; c < x + w; c++)
                if (c < 64 && r < 32) push_one(ta(c, r), v[1:0]);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        exp_q.delete();
        obs_q.delete();
        done_q.delete();
    endtask

    task automatic send_cmd(int x, int y, int w, int h, int v, output int acc);
        bus.cmd_x = x[5:0];
        bus.cmd_y = y[4:0];
        bus.cmd_w = w[6:0];
        bus.cmd_h = h[5:0];
        bus.cmd_val = v[1:0];
        bus.cmd_valid = 1'b1;
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL cmd_ready_before_send got=%b want=1", bus.cmd_ready);
        end
        cyc();
        acc = cyc_n;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic check_writes(string nm, int acc, int lim);
        int n;
        for (int i = 0; i < lim; i++) begin
            if (done_q.size() > 0) break;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (done_q.size() != 1) begin
            errors++;
            $display("FAIL %s done_pulses got=%0d want=1", nm, done_q.size());
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s write_count got=%0d want=%0d",
                     nm, obs_q.size(), exp_q.size());
        end
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            checks++;
            if (obs_q[i].addr !== exp_q[i].addr || obs_q[i].din !== exp_q[i].din ||
                obs_q[i].cyc != acc + i) begin
                errors++;
                $display("FAIL %s write%0d got addr=%h din=%0d cyc=%0d want addr=%h din=%0d cyc=%0d",
                         nm, i, obs_q[i].addr, obs_q[i].din, obs_q[i].cyc,
                         exp_q[i].addr, exp_q[i].din, acc + i);
            end
        end
        if (done_q.size() > 0) begin
            checks++;
            if (obs_q.size() > 0) begin
                if (done_q[0] != obs_q[obs_q.size()-1].cyc + 1) begin
                    errors++;
                    $display("FAIL %s done_cycle got=%0d want=%0d",
                             nm, done_q[0], obs_q[obs_q.size()-1].cyc + 1);
                end
            end else if (done_q[0] < acc || done_q[0] > acc + 2) begin
                errors++;
                $display("FAIL %s done_latency got=%0d want<=2", nm, done_q[0] - acc);
            end
        end
        checks++;
        if (bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s idle_after got busy=%b ready=%b want busy=0 ready=1",
                     nm, bus.busy, bus.cmd_ready);
        end
        flush();
    endtask

    task automatic test_reset();
        bus.cpu_we = 1'b0;
        bus.cpu_addr = '0;
        bus.cpu_din = '0;
        bus.cmd_valid = 1'b0;
        bus.cmd_x = '0;
        bus.cmd_y = '0;
        bus.cmd_w = '0;
        bus.cmd_h = '0;
        bus.cmd_val = '0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.we !== 1'b0 || bus.addr !== 11'd0 || bus.din !== 2'd0 ||
            bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got we=%b addr=%h din=%0d busy=%b done=%b want all 0",
                     bus.we, bus.addr, bus.din, bus.busy, bus.done);
        end
        repeat (3) cyc();
        rst_n = 1'b1;
        cyc();
        checks++;
        if (bus.cmd_ready !== 1'b1 || bus.we !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got ready=%b we=%b want ready=1 we=0",
                     bus.cmd_ready, bus.we);
        end
        flush();
    endtask

    task automatic test_basic();
        int acc;
        push_fill(2, 3, 3, 2, 1);
        send_cmd(2, 3, 3, 2, 1, acc);
        check_writes("basic", acc, 50);
    endtask

    task automatic test_clip();
        int acc;
        push_one(ta(62, 31), 2'd2);
        push_one(ta(63, 31), 2'd2);
        send_cmd(62, 31, 4, 3, 2, acc);
        check_writes("clip", acc, 50);
    endtask

    task automatic test_single();
        int acc;
        push_fill(63, 31, 1, 1, 3);
        send_cmd(63, 31, 1, 1, 3, acc);
        check_writes("single", acc, 50);
    endtask

    task automatic test_zero();
        int acc;
        send_cmd(4, 4, 0, 5, 1, acc);
        check_writes("zero_w", acc, 20);
        send_cmd(4, 4, 3, 0, 1, acc);
        check_writes("zero_h", acc, 20);
    endtask

    task automatic test_cpu_contention();
        int acc;
        push_one(ta(10, 5), 2'd3);
        push_one(11'h155, 2'd2);
        push_one(11'h2aa, 2'd1);
        push_one(ta(11, 5), 2'd3);
        push_one(ta(12, 5), 2'd3);
        push_one(ta(13, 5), 2'd3);
        send_cmd(10, 5, 4, 1, 3, acc);
        bus.cpu_we = 1'b1;
        bus.cpu_addr = 11'h155;
        bus.cpu_din = 2'd2;
        cyc();
        bus.cpu_addr = 11'h2aa;
        bus.cpu_din = 2'd1;
        cyc();
        bus.cpu_we = 1'b0;
        check_writes("cpu_prio", acc, 50);
    endtask

    task automatic test_busy_ignore();
        int acc;
        push_fill(20, 10, 3, 3, 2);
        send_cmd(20, 10, 3, 3, 2, acc);
        bus.cmd_x = 6'd1;
        bus.cmd_y = 5'd1;
        bus.cmd_w = 7'd2;
        bus.cmd_h = 6'd2;
        bus.cmd_val = 2'd3;
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.cmd_ready !== 1'b0 || bus.busy !== 1'b1) begin
                errors++;
                $display("FAIL busy_ignore got ready=%b busy=%b want ready=0 busy=1",
                         bus.cmd_ready, bus.busy);
            end
            cyc();
        end
        bus.cmd_valid = 1'b0;
        check_writes("busy_ignore", acc, 50);
    endtask

    task automatic test_reset_mid();
        int acc;
        send_cmd(0, 0, 8, 4, 1, acc);
        repeat (5) cyc();
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.we !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid got we=%b busy=%b done=%b want 0",
                     bus.we, bus.busy, bus.done);
        end
        flush();
        repeat (2) cyc();
        rst_n = 1'b1;
        repeat (40) cyc();
        checks++;
        if (obs_q.size() != 0 || done_q.size() != 0 || bus.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_abort got writes=%0d dones=%0d ready=%b want 0 0 1",
                     obs_q.size(), done_q.size(), bus.cmd_ready);
        end
        flush();
    endtask

    task automatic test_back_to_back();
        int acc;
        push_fill(30, 20, 2, 2, 1);
        send_cmd(30, 20, 2, 2, 1, acc);
        check_writes("b2b_a", acc, 50);
        push_fill(0, 30, 5, 2, 2);
        send_cmd(0, 30, 5, 2, 2, acc);
        check_writes("b2b_b", acc, 50);
    endtask

`ifdef UI_FILL_CLEAR_EN
    task automatic test_clear();
        int acc;
        push_fill(0, 0, 64, 32, 0);
        bus.cmd_x = 6'd5;
        bus.cmd_y = 5'd5;
        bus.cmd_w = 7'd2;
        bus.cmd_h = 6'd2;
        bus.cmd_val = 2'd3;
        bus.cmd_valid = 1'b1;
        clear_req = 1'b1;
        #1;
        checks++;
        if (bus.cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL clear_ready got=%b want=0", bus.cmd_ready);
        end
        cyc();
        acc = cyc_n;
        clear_req = 1'b0;
        bus.cmd_valid = 1'b0;
        check_writes("clear", acc, 2200);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_clip();
        test_single();
        test_zero();
        test_cpu_contention();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
`ifdef UI_FILL_CLEAR_EN
        test_clear();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
